// File: rtl/inst_sequencer_pkg.sv
// Shared types and defaults for the RV32E multi-cycle instruction sequencer.
package inst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IWAIT = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MREQ  = 3'd3,
    ST_MWAIT = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6,
    ST_ERR   = 3'd7
  } seq_state_e;

  localparam int unsigned SEQ_TIMEOUT    = 1024;
  localparam int unsigned SEQ_CNT_W      = 11;
  localparam logic [31:0] SEQ_RESET_INST = 32'h0000_0013;

  // States that block on an external handshake and are guarded by the wait timer.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_IWAIT) || (s == ST_MREQ) || (s == ST_MWAIT);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-state watchdog: counts stalled cycles, clears on exit, flags expiry.
module seq_wait_timer
  import inst_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = SEQ_TIMEOUT,
  parameter int unsigned CNT_W       = SEQ_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic done,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stalled;

  assign stalled = active && !done;
  assign expired = stalled && (cnt_q == LAST);

  // Any state change (exit or expiry) restarts the count from zero.
  always_comb begin
    cnt_d = '0;
    if (stalled && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer driving fetch and LSU handshakes.
//
// state | meaning
// FETCH | fetch request out, wait for if_req_ready
// IWAIT | wait for if_rsp_valid, latch instruction
// EXEC  | sample decoder, pick memory / write-back / halt
// MREQ  | data request out, wait for mem_req_ready
// MWAIT | wait for mem_rsp_valid
// WB    | one-cycle commit strobes
// HALT  | ebreak retired, idle until reset
// ERR   | handshake timeout, idle until reset
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = SEQ_TIMEOUT,
  parameter int unsigned CNT_W       = SEQ_CNT_W,
  parameter logic [31:0] RESET_INST  = SEQ_RESET_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic [31:0] inst_q,
  input  logic        dec_wen_r,
  input  logic        dec_wen_m,
  input  logic        dec_is_load,
  input  logic        dec_halt,
  output logic        mem_req_valid,
  output logic        mem_req_wen,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halted,
  output logic        timeout,
  output logic [2:0]  state_o
);

  seq_state_e  state_q, state_d;
  logic [31:0] inst_d;
  logic        mem_wen_q, mem_wen_d;
  logic        rf_wen_q, rf_wen_d;
  logic        wait_active, wait_done, wait_expired;

  assign wait_active = is_wait_state(state_q);

  always_comb begin
    wait_done = 1'b0;
    case (state_q)
      ST_FETCH: wait_done = if_req_ready;
      ST_IWAIT: wait_done = if_rsp_valid;
      ST_MREQ:  wait_done = mem_req_ready;
      ST_MWAIT: wait_done = mem_rsp_valid;
      default:  wait_done = 1'b0;
    endcase
  end

  seq_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (wait_active),
    .done    (wait_done),
    .expired (wait_expired)
  );

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    mem_wen_d = mem_wen_q;
    rf_wen_d  = rf_wen_q;
    case (state_q)
      ST_FETCH: if (if_req_ready) state_d = ST_IWAIT;
      ST_IWAIT: begin
        if (if_rsp_valid) begin
          inst_d  = if_rsp_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Store beats load when the decoder asserts both.
        if (dec_halt) begin
          state_d = ST_HALT;
        end else if (dec_wen_m) begin
          mem_wen_d = 1'b1;
          rf_wen_d  = 1'b0;
          state_d   = ST_MREQ;
        end else if (dec_is_load) begin
          mem_wen_d = 1'b0;
          rf_wen_d  = dec_wen_r;
          state_d   = ST_MREQ;
        end else begin
          rf_wen_d = dec_wen_r;
          state_d  = ST_WB;
        end
      end
      ST_MREQ:  if (mem_req_ready) state_d = ST_MWAIT;
      ST_MWAIT: if (mem_rsp_valid) state_d = ST_WB;
      ST_WB:    state_d = ST_FETCH;
      default:  state_d = state_q;
    endcase
    if (wait_expired) state_d = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      inst_q    <= RESET_INST;
      mem_wen_q <= 1'b0;
      rf_wen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      mem_wen_q <= mem_wen_d;
      rf_wen_q  <= rf_wen_d;
    end
  end

  assign if_req_valid  = (state_q == ST_FETCH);
  assign mem_req_valid = (state_q == ST_MREQ);
  assign mem_req_wen   = mem_wen_q;
  assign rf_we         = (state_q == ST_WB) && rf_wen_q;
  assign pc_we         = (state_q == ST_WB);
  assign halted        = (state_q == ST_HALT);
  assign timeout       = (state_q == ST_ERR);
  assign state_o       = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer with a cycle-level reference model and trace checks.
module tb_inst_sequencer;

  localparam int TO = 8;
  localparam int TR = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid, if_req_ready = 1'b0, if_rsp_valid = 1'b0;
  logic [31:0] if_rsp_data = 32'h0;
  logic [31:0] inst_q;
  logic        dec_wen_r = 1'b0, dec_wen_m = 1'b0, dec_is_load = 1'b0, dec_halt = 1'b0;
  logic        mem_req_valid, mem_req_wen, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic        rf_we, pc_we, halted, timeout;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  inst_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(4), .RESET_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .inst_q(inst_q),
    .dec_wen_r(dec_wen_r), .dec_wen_m(dec_wen_m), .dec_is_load(dec_is_load), .dec_halt(dec_halt),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .timeout(timeout), .state_o(state_o)
  );

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  // Reference model: spec-level state number, latched instruction and decode flags.
  int          m_state = 0;
  int          m_wait  = 0;
  logic [31:0] m_inst  = 32'h13;
  logic        m_wen   = 1'b0;
  logic        m_rfw   = 1'b0;

  always @(posedge clk) begin
    int          nxt, w;
    logic [31:0] ni;
    logic        nw, nr;
    bit          waiting;
    if (!rst_n) begin
      m_state <= 0; m_wait <= 0; m_inst <= 32'h13; m_wen <= 1'b0; m_rfw <= 1'b0;
    end else begin
      nxt = m_state; ni = m_inst; nw = m_wen; nr = m_rfw;
      case (m_state)
        0: if (if_req_ready) nxt = 1;
        1: if (if_rsp_valid) begin ni = if_rsp_data; nxt = 2; end
        2: begin
          if (dec_halt) nxt = 6;
          else if (dec_wen_m) begin nxt = 3; nw = 1'b1; nr = 1'b0; end
          else if (dec_is_load) begin nxt = 3; nw = 1'b0; nr = dec_wen_r; end
          else begin nxt = 5; nr = dec_wen_r; end
        end
        3: if (mem_req_ready) nxt = 4;
        4: if (mem_rsp_valid) nxt = 5;
        5: nxt = 0;
        default: nxt = m_state;
      endcase
      waiting = (m_state == 0) || (m_state == 1) || (m_state == 3) || (m_state == 4);
      w = 0;
      if (waiting && nxt == m_state) begin
        if (m_wait >= TO - 1) nxt = 7;
        else w = m_wait + 1;
      end
      m_state <= nxt; m_wait <= w; m_inst <= ni; m_wen <= nw; m_rfw <= nr;
    end
  end

  always @(negedge clk) begin
    logic [41:0] got, exp;
    if (started) begin
      got = {state_o, if_req_valid, mem_req_valid, mem_req_wen, rf_we, pc_we, halted, timeout, inst_q};
      exp = {m_state[2:0], m_state == 0, m_state == 3, m_wen, (m_state == 5) && m_rfw,
             m_state == 5, m_state == 6, m_state == 7, m_inst};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t got {st,ifv,mv,mw,rf,pc,h,to,inst}=%h required %h", $time, got, exp);
      end
    end
  end

  // Bus responders and per-test traces.
  int if_rdy_dly, if_rsp_dly, mem_rdy_dly, mem_rsp_dly;
  int if_age, if_rsp_wait, mem_age, mem_rsp_wait;
  bit spurious;
  logic [31:0] next_inst;
  int idx;
  logic [2:0]  st_tr [TR];
  logic        iv_tr [TR], mv_tr [TR], mw_tr [TR], rf_tr [TR], pc_tr [TR], h_tr [TR], to_tr [TR];
  logic [31:0] in_tr [TR];

  task automatic clear_bus();
    if_req_ready = 0; if_rsp_valid = 0; if_rsp_data = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    if_age = 0; if_rsp_wait = 0; mem_age = 0; mem_rsp_wait = 0;
  endtask

  task automatic sample_drive();
    if (idx < TR) begin
      st_tr[idx] = state_o; iv_tr[idx] = if_req_valid; mv_tr[idx] = mem_req_valid;
      mw_tr[idx] = mem_req_wen; rf_tr[idx] = rf_we; pc_tr[idx] = pc_we;
      h_tr[idx] = halted; to_tr[idx] = timeout; in_tr[idx] = inst_q;
    end
    idx++;
    if_rsp_valid = 0; if_rsp_data = 32'h0;
    if (if_rsp_wait > 0) begin
      if_rsp_wait--;
      if (if_rsp_wait == 0) begin if_rsp_valid = 1; if_rsp_data = next_inst; end
    end
    if (if_req_valid) begin
      if (spurious) begin if_rsp_valid = 1; if_rsp_data = 32'hdead_beef; end
      if_req_ready = (if_age == if_rdy_dly);
      if_age++;
      if (if_req_ready) if_rsp_wait = if_rsp_dly;
    end else begin
      if_req_ready = 0; if_age = 0;
    end
    mem_rsp_valid = 0;
    if (mem_rsp_wait > 0) begin
      mem_rsp_wait--;
      if (mem_rsp_wait == 0) mem_rsp_valid = 1;
    end
    if (mem_req_valid) begin
      mem_req_ready = (mem_age == mem_rdy_dly);
      mem_age++;
      if (mem_req_ready) mem_rsp_wait = mem_rsp_dly;
    end else begin
      mem_req_ready = 0; mem_age = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start();
    @(negedge clk);
    rst_n = 0;
    clear_bus();
    @(negedge clk);
    rst_n = 1;
    idx = 0;
    sample_drive();
  endtask

  task automatic setup(input int ir, input int irs, input int mr, input int mrs, input logic [31:0] inst,
                       input logic wr, input logic wm, input logic ld, input logic h);
    if_rdy_dly = ir; if_rsp_dly = irs; mem_rdy_dly = mr; mem_rsp_dly = mrs; next_inst = inst;
    dec_wen_r = wr; dec_wen_m = wm; dec_is_load = ld; dec_halt = h; spurious = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  function automatic int cnt(input int which, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) begin
      case (which)
        0: n += int'(iv_tr[i]);
        1: n += int'(mv_tr[i]);
        2: n += int'(rf_tr[i]);
        3: n += int'(pc_tr[i]);
        4: n += int'(mv_tr[i] && mw_tr[i]);
        default: n += int'(st_tr[i] == 3'd0);
      endcase
    end
    return n;
  endfunction

  initial begin
    clear_bus();
    setup(0, 1, 0, 1, 32'h0050_0093, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    started = 1;

    // addi, zero-wait
    do_start();
    chk("reset_state", 32'(st_tr[0]), 0);
    chk("reset_inst", in_tr[0], 32'h13);
    chk("reset_flags", {29'd0, h_tr[0], to_tr[0], mw_tr[0]}, 0);
    run(5);
    chk("addi_iwait", 32'(st_tr[1]), 1);
    chk("addi_inst_exec", in_tr[2], 32'h0050_0093);
    chk("addi_c4_strobes", {30'd0, rf_tr[3], pc_tr[3]}, 3);
    chk("addi_c5_fetch", 32'(st_tr[4]), 0);
    chk("addi_rf_pulses", cnt(2, 0, 5), 1);

    // rsp during FETCH must be ignored
    setup(2, 1, 0, 1, 32'h0010_0113, 1, 0, 0, 0);
    spurious = 1;
    do_start();
    run(7);
    chk("spurious_inst_exec", in_tr[4], 32'h0010_0113);

    // lw zero-wait: 6 cycles
    setup(0, 1, 0, 1, 32'h0000_2083, 1, 0, 1, 0);
    do_start();
    run(7);
    chk("lw0_wb", {30'd0, rf_tr[5], pc_tr[5]}, 3);
    chk("lw0_fetch_c7", 32'(st_tr[6]), 0);

    // lw, ready delayed 3, rsp 2 later
    setup(0, 1, 3, 2, 32'h0000_2083, 1, 0, 1, 0);
    do_start();
    run(11);
    chk("lw_mreq_cycles", cnt(1, 0, 11), 4);
    chk("lw_mreq_is_load", cnt(4, 0, 11), 0);
    chk("lw_rf_at_9", 32'(rf_tr[9]), 1);
    chk("lw_rf_pulses", cnt(2, 0, 11), 1);
    chk("lw_fetch_10", 32'(st_tr[10]), 0);

    // sw, ready after one stall
    setup(0, 1, 1, 1, 32'h0010_2023, 0, 1, 0, 0);
    do_start();
    run(8);
    chk("sw_wen_whole_req", cnt(4, 0, 8), 2);
    chk("sw_wb", {30'd0, rf_tr[6], pc_tr[6]}, 1);
    chk("sw_rf_pulses", cnt(2, 0, 8), 0);

    // store and load both set: store wins
    setup(0, 1, 0, 1, 32'h0010_2023, 1, 1, 1, 0);
    do_start();
    run(7);
    chk("both_is_store", cnt(4, 0, 7), 1);
    chk("both_no_rf", cnt(2, 0, 7), 0);

    // ebreak
    setup(0, 1, 0, 1, 32'h0010_0073, 1, 0, 0, 1);
    do_start();
    run(104);
    chk("halt_state", 32'(st_tr[3]), 6);
    chk("halted_flag", 32'(h_tr[3]), 1);
    chk("halt_no_fetch", cnt(0, 4, 103), 0);
    chk("halt_no_strobes", cnt(2, 0, 104) + cnt(3, 0, 104), 0);
    chk("halt_still", 32'(h_tr[104]), 1);
    do_start();
    chk("halt_reset_state", 32'(st_tr[0]), 0);
    chk("halt_reset_inst", in_tr[0], 32'h13);
    chk("halt_reset_flag", 32'(h_tr[0]), 0);

    // FETCH timeout: ready never
    setup(100, 1, 0, 1, 32'h0050_0093, 1, 0, 0, 0);
    do_start();
    run(11);
    chk("to_fetch_cycles", cnt(5, 0, 7), 8);
    chk("to_err_state", 32'(st_tr[8]), 7);
    chk("to_flag", 32'(to_tr[8]), 1);
    chk("to_sticky", {30'd0, to_tr[11], iv_tr[11]}, 2);

    // ready on the 8th FETCH cycle: exit wins
    setup(7, 1, 0, 1, 32'h0050_0093, 1, 0, 0, 0);
    do_start();
    run(12);
    chk("edge_iwait", 32'(st_tr[8]), 1);
    chk("edge_no_to", 32'(to_tr[8]), 0);
    chk("edge_retired", 32'(st_tr[11]), 0);

    // IWAIT timeout: rsp never
    setup(0, 0, 0, 1, 32'h0050_0093, 1, 0, 0, 0);
    do_start();
    run(10);
    chk("iwait_last", 32'(st_tr[8]), 1);
    chk("iwait_err", 32'(st_tr[9]), 7);

    // reset during MWAIT
    setup(0, 1, 0, 5, 32'h0000_2083, 1, 0, 1, 0);
    do_start();
    run(5);
    chk("pre_rst_mwait", 32'(st_tr[5]), 4);
    rst_n = 0;
    clear_bus();
    @(negedge clk);
    chk("mrst_state", 32'(state_o), 0);
    chk("mrst_outs", {29'd0, rf_we, pc_we, mem_req_valid}, 0);
    rst_n = 1;
    clear_bus();
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
